// File: rtl/lag_router_input_unit_pkg.sv
// Shared types for the LAG router input unit: flit layout, per-PL packet state, error bit positions.
package LAG_pkg;
   localparam int DATA_W       = 16;
   localparam int ERR_OVERFLOW = 0;
   localparam int ERR_PROTOCOL = 1;

   typedef struct packed {
      logic head;
      logic tail;
      logic valid;
   } control_t;

   typedef struct packed {
      control_t          control;
      logic [DATA_W-1:0] data;
   } flit_t;

   typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, ACTIVE = 2'd2} pl_state_t;
endpackage

// File: rtl/lag_router_input_unit_if.sv
// Link-side and allocator-side signals of one router input unit; master drives the unit, slave is the unit.
interface lag_router_input_unit_if #(
   parameter int NT  = 5,
   parameter int NPL = 4
);
   import LAG_pkg::*;

   flit_t [NPL-1:0]           flit_in;
   logic  [NPL-1:0]           grant_valid;
   logic  [NPL-1:0][NPL-1:0]  grant_pl;
   logic  [NPL-1:0]           pl_blocked;
   flit_t [NPL-1:0]           flit_out;
   logic  [NPL-1:0]           pl_req;
   logic  [NPL-1:0][NT-1:0]   out_port;
   logic  [NPL-1:0][NPL-1:0]  alloc_pl;
   logic  [NPL-1:0]           alloc_valid;
   logic  [NPL-1:0]           credits_out;
   logic  [NPL-1:0]           full;
   logic  [1:0]               err;

   modport master (
      output flit_in, grant_valid, grant_pl, pl_blocked,
      input  flit_out, pl_req, out_port, alloc_pl, alloc_valid, credits_out, full, err
   );
   modport slave (
      input  flit_in, grant_valid, grant_pl, pl_blocked,
      output flit_out, pl_req, out_port, alloc_pl, alloc_valid, credits_out, full, err
   );
endinterface

// File: rtl/lag_router_input_unit_fifo.sv
// lag_flit_fifo: per-PL flit buffer, registered head (no bypass); a push into a full FIFO is dropped unless a pop frees the slot.
module lag_flit_fifo
   import LAG_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic                     pop,
   input  flit_t                    din,
   output flit_t                    dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     overflow
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

   flit_t          mem [DEPTH];
   logic [AW-1:0]  wr_ptr, rd_ptr;
   logic           wr_en, rd_en;

   assign full     = (count == CNT_FULL);
   assign empty    = (count == '0);
   assign rd_en    = pop && !empty;
   assign wr_en    = push && (!full || rd_en);
   assign overflow = push && full && !rd_en;
   assign dout     = mem[rd_ptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + 1'b1;
         if (rd_en) rd_ptr <= rd_ptr + 1'b1;
         count <= count + {{AW{1'b0}}, wr_en} - {{AW{1'b0}}, rd_en};
      end
   end

   always_ff @(posedge clk)
      if (wr_en) mem[wr_ptr] <= din;
endmodule

// File: rtl/lag_router_input_unit.sv
// LAG NoC router input unit: NPL flit FIFOs, per-PL packet FSM, output-port/PL latches, upstream credits.
// Build option LAG_REG_CREDITS_EN registers credits_out one cycle after the pop.
module lag_router_input_unit
   import LAG_pkg::*;
#(
   parameter int NT            = 5,
   parameter int NPL           = 4,
   parameter int BUF_LEN       = 4,
   parameter int NUM_PLS_ENTRY = 4
) (
   input  logic clk,
   input  logic rst_n,
   lag_router_input_unit_if.slave bus
);
   localparam int CW = $clog2(BUF_LEN) + 1;

   flit_t [NPL-1:0]           head, flit_out;
   logic  [NPL-1:0]           empty, full, overflow, pop, perr, pl_req, alloc_valid;
   logic  [NPL-1:0][NT-1:0]   port_now;
   logic  [NPL-1:0][NPL-1:0]  alloc_pl;
   logic  [1:0]               err_q;

   for (genvar j = 0; j < NPL; j++) begin : g_pl
      localparam bit CAN_REQ = (j < NUM_PLS_ENTRY);
      pl_state_t       state_q, state_d;
      logic [CW-1:0]   count;
      logic            front_head, front_body, req_phase, grant_ok, lane_pop, lane_perr;
      logic [NT-1:0]   port_q;
      logic [NPL-1:0]  alloc_q;
      flit_t           fo;

      lag_flit_fifo #(.DEPTH(BUF_LEN)) u_fifo (
         .clk      (clk),
         .rst_n    (rst_n),
         .push     (bus.flit_in[j].control.valid),
         .pop      (lane_pop),
         .din      (bus.flit_in[j]),
         .dout     (head[j]),
         .full     (full[j]),
         .empty    (empty[j]),
         .count    (count),
         .overflow (overflow[j])
      );

      assign front_head = !empty[j] && head[j].control.head;
      assign front_body = !empty[j] && !head[j].control.head;
      // An idle PL with a head at the front requests in that same cycle so a grant can land one cycle after the push.
      assign req_phase  = CAN_REQ && ((state_q == IDLE && front_head) || state_q == REQ);
      assign grant_ok   = req_phase && bus.grant_valid[j] && $onehot(bus.grant_pl[j]);
      assign port_now[j] = front_head ? head[j].data[NT-1:0] : port_q;

      always_ff @(posedge clk or negedge rst_n)
         if (!rst_n) state_q <= IDLE;
         else        state_q <= state_d;

      always_comb begin
         state_d = state_q;
         case (state_q)
            IDLE:    if (front_head) state_d = grant_ok ? ACTIVE : REQ;
            REQ:     if (grant_ok) state_d = ACTIVE;
            ACTIVE:  if (lane_pop && head[j].control.tail) state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end

      always_comb begin
         lane_pop  = (state_q == ACTIVE) && !empty[j] && !bus.pl_blocked[j];
         lane_perr = (state_q == IDLE && front_body) ||
                     (req_phase && bus.grant_valid[j] && !$onehot(bus.grant_pl[j]));
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            port_q  <= '0;
            alloc_q <= '0;
         end else if (grant_ok) begin
            port_q  <= port_now[j];
            alloc_q <= bus.grant_pl[j];
         end else if (lane_pop && head[j].control.tail) begin
            alloc_q <= '0;
         end
      end

      always_comb begin
         fo = head[j];
         fo.control.valid = lane_pop;
         if (empty[j]) fo = '0;
      end

      assign pop[j]         = lane_pop;
      assign perr[j]        = lane_perr;
      assign pl_req[j]      = req_phase;
      assign alloc_valid[j] = (state_q == ACTIVE);
      assign alloc_pl[j]    = alloc_q;
      assign flit_out[j]    = fo;

      a_count_bound: assert property (@(posedge clk) disable iff (!rst_n) count <= CW'(BUF_LEN));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_q <= '0;
      end else begin
         err_q[ERR_OVERFLOW] <= err_q[ERR_OVERFLOW] | (|overflow);
         err_q[ERR_PROTOCOL] <= err_q[ERR_PROTOCOL] | (|perr);
      end
   end

`ifdef LAG_REG_CREDITS_EN
   logic [NPL-1:0] cred_q;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) cred_q <= '0;
      else        cred_q <= pop;
   assign bus.credits_out = cred_q;
`else
   assign bus.credits_out = pop;
`endif

   assign bus.flit_out    = flit_out;
   assign bus.pl_req      = pl_req;
   assign bus.out_port    = port_now;
   assign bus.alloc_pl    = alloc_pl;
   assign bus.alloc_valid = alloc_valid;
   assign bus.full        = full;
   assign bus.err         = err_q;
endmodule

// File: tb/tb_lag_router_input_unit.sv
// Scenario bench for lag_router_input_unit: expected flits queued per PL at push, compared when popped.
module tb_lag_router_input_unit;
   import LAG_pkg::*;

   localparam int NT = 5, NPL = 4, BUF_LEN = 4, NUM_PLS_ENTRY = 3;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   lag_router_input_unit_if #(.NT(NT), .NPL(NPL)) bus ();

   lag_router_input_unit #(
      .NT(NT), .NPL(NPL), .BUF_LEN(BUF_LEN), .NUM_PLS_ENTRY(NUM_PLS_ENTRY)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int checks = 0;
   int passed = 0;
   flit_t sb_q [NPL][$];
   logic [NPL-1:0] prev_pop = '0;

   // Scoreboard: every pop must match the oldest queued flit; credits follow pops.
   always @(negedge clk) begin : mon
      logic [NPL-1:0] cur_pop, exp_cred;
      flit_t exp;
      cur_pop = '0;
      if (rst_n) begin
         for (int j = 0; j < NPL; j++) begin
            cur_pop[j] = bus.flit_out[j].control.valid;
            if (cur_pop[j]) begin
               checks++;
               if (sb_q[j].size() == 0) begin
                  $display("FAIL sb_pop pl%0d: got data %h, required no pop", j, bus.flit_out[j].data);
               end else begin
                  exp = sb_q[j].pop_front();
                  if (bus.flit_out[j].data !== exp.data || bus.flit_out[j].control.head !== exp.control.head ||
                      bus.flit_out[j].control.tail !== exp.control.tail)
                     $display("FAIL sb_pop pl%0d: got %h h%0b t%0b, required %h h%0b t%0b", j,
                              bus.flit_out[j].data, bus.flit_out[j].control.head, bus.flit_out[j].control.tail,
                              exp.data, exp.control.head, exp.control.tail);
                  else passed++;
               end
            end
         end
`ifdef LAG_REG_CREDITS_EN
         exp_cred = prev_pop;
`else
         exp_cred = cur_pop;
`endif
         if (exp_cred != '0 || bus.credits_out != '0) begin
            checks++;
            if (bus.credits_out !== exp_cred)
               $display("FAIL credits: got %b, required %b", bus.credits_out, exp_cred);
            else passed++;
         end
      end
      prev_pop = cur_pop;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      bus.flit_in     = '0;
      bus.grant_valid = '0;
      bus.grant_pl    = '0;
      bus.pl_blocked  = '0;
   endtask

   task automatic drive_flit(input int j, input bit h, input bit t, input logic [DATA_W-1:0] d, input bit will_pop);
      flit_t f;
      f.control.head  = h;
      f.control.tail  = t;
      f.control.valid = 1'b1;
      f.data          = d;
      bus.flit_in[j]  = f;
      if (will_pop) sb_q[j].push_back(f);
   endtask

   task automatic do_reset();
      step();
      idle_inputs();
      rst_n = 1'b0;
      for (int j = 0; j < NPL; j++) sb_q[j].delete();
      step();
      step();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst_n = 1'b0;
      #12;
      checks++;
      if (bus.flit_out !== '0 || bus.pl_req !== '0 || bus.alloc_valid !== '0 || bus.credits_out !== '0)
         $display("FAIL reset_out: got flit %h req %b av %b cr %b, required all 0",
                  bus.flit_out, bus.pl_req, bus.alloc_valid, bus.credits_out);
      else passed++;
      checks++;
      if (bus.full !== '0 || bus.err !== 2'b00 || bus.out_port !== '0 || bus.alloc_pl !== '0)
         $display("FAIL reset_state: got full %b err %b port %h apl %h, required all 0",
                  bus.full, bus.err, bus.out_port, bus.alloc_pl);
      else passed++;
      step();
      rst_n = 1'b1;
      mid();
   endtask

   task automatic test_single_flit();
      step(); idle_inputs();
      drive_flit(0, 1, 1, 16'hA504, 1);
      mid();
      checks++;
      if (bus.pl_req !== 4'b0000) $display("FAIL single_nobypass: got pl_req %b, required 0000", bus.pl_req); else passed++;
      step(); idle_inputs();
      bus.grant_valid[0] = 1'b1;
      bus.grant_pl[0]    = 4'b0010;
      mid();
      checks++;
      if (bus.pl_req !== 4'b0001 || bus.out_port[0] !== 5'b00100)
         $display("FAIL single_req: got pl_req %b port %b, required 0001 00100", bus.pl_req, bus.out_port[0]);
      else passed++;
      step(); idle_inputs();
      mid();
      checks++;
      if (bus.alloc_valid !== 4'b0001 || bus.alloc_pl[0] !== 4'b0010 || bus.flit_out[0].control.valid !== 1'b1)
         $display("FAIL single_active: got av %b apl %b pop %b, required 0001 0010 1",
                  bus.alloc_valid, bus.alloc_pl[0], bus.flit_out[0].control.valid);
      else passed++;
      step(); idle_inputs();
      mid();
      checks++;
      if (bus.alloc_valid !== 4'b0000 || bus.pl_req !== 4'b0000 || bus.full !== 4'b0000)
         $display("FAIL single_idle: got av %b req %b full %b, required 0000 0000 0000",
                  bus.alloc_valid, bus.pl_req, bus.full);
      else passed++;
   endtask

   task automatic test_blocked();
      step(); idle_inputs();
      drive_flit(1, 1, 0, 16'h1102, 1);
      mid();
      step(); idle_inputs();
      drive_flit(1, 0, 0, 16'h1200, 1);
      bus.grant_valid[1] = 1'b1;
      bus.grant_pl[1]    = 4'b0100;
      mid();
      checks++;
      if (bus.pl_req[1] !== 1'b1) $display("FAIL blk_req: got %b, required 1", bus.pl_req[1]); else passed++;
      for (int k = 0; k < 3; k++) begin
         step(); idle_inputs();
         bus.pl_blocked[1] = 1'b1;
         if (k == 0) drive_flit(1, 0, 1, 16'h1300, 1);
         mid();
         checks++;
         if (bus.alloc_valid[1] !== 1'b1 || bus.flit_out[1].control.valid !== 1'b0 || bus.credits_out[1] !== 1'b0)
            $display("FAIL blk_hold%0d: got av %b pop %b, required 1 0", k, bus.alloc_valid[1], bus.flit_out[1].control.valid);
         else passed++;
      end
      for (int k = 0; k < 3; k++) begin
         step(); idle_inputs();
         mid();
         checks++;
         if (bus.flit_out[1].control.valid !== 1'b1 || bus.out_port[1] !== 5'b00010 || bus.alloc_pl[1] !== 4'b0100)
            $display("FAIL blk_drain%0d: got pop %b port %b apl %b, required 1 00010 0100",
                     k, bus.flit_out[1].control.valid, bus.out_port[1], bus.alloc_pl[1]);
         else passed++;
      end
      step(); idle_inputs();
      mid();
      checks++;
      if (bus.alloc_valid[1] !== 1'b0) $display("FAIL blk_idle: got %b, required 0", bus.alloc_valid[1]); else passed++;
   endtask

   task automatic test_overflow();
      do_reset();
      for (int k = 0; k < 4; k++) begin
         step(); idle_inputs();
         drive_flit(2, k == 0, 0, 16'h2000 + 16'(k), 1);
         mid();
      end
      step(); idle_inputs();
      drive_flit(2, 0, 0, 16'h20FF, 0);
      mid();
      checks++;
      if (bus.full !== 4'b0100 || bus.err !== 2'b00 || bus.pl_req[2] !== 1'b1)
         $display("FAIL ovf_full: got full %b err %b req %b, required 0100 00 1", bus.full, bus.err, bus.pl_req[2]);
      else passed++;
      step(); idle_inputs();
      bus.grant_valid[2] = 1'b1;
      bus.grant_pl[2]    = 4'b0001;
      mid();
      checks++;
      if (bus.err !== 2'b01 || bus.full !== 4'b0100)
         $display("FAIL ovf_drop: got err %b full %b, required 01 0100", bus.err, bus.full);
      else passed++;
      step(); idle_inputs();
      drive_flit(2, 0, 1, 16'h2004, 1);
      mid();
      checks++;
      if (bus.flit_out[2].control.valid !== 1'b1) $display("FAIL ovf_pushpop: got pop %b, required 1", bus.flit_out[2].control.valid); else passed++;
      step(); idle_inputs();
      mid();
      checks++;
      if (bus.full !== 4'b0100 || bus.err !== 2'b01)
         $display("FAIL ovf_count: got full %b err %b, required 0100 01", bus.full, bus.err);
      else passed++;
      for (int k = 0; k < 4; k++) begin step(); idle_inputs(); mid(); end
      checks++;
      if (bus.alloc_valid !== 4'b0000 || bus.full !== 4'b0000)
         $display("FAIL ovf_drained: got av %b full %b, required 0000 0000", bus.alloc_valid, bus.full);
      else passed++;
   endtask

   task automatic test_protocol();
      do_reset();
      step(); idle_inputs();
      drive_flit(1, 0, 0, 16'h3300, 0);
      mid();
      step(); idle_inputs();
      mid();
      checks++;
      if (bus.pl_req[1] !== 1'b0 || bus.err !== 2'b00)
         $display("FAIL proto_pre: got req %b err %b, required 0 00", bus.pl_req[1], bus.err);
      else passed++;
      step(); idle_inputs();
      mid();
      checks++;
      if (bus.err !== 2'b10 || bus.pl_req[1] !== 1'b0 || bus.flit_out[1].control.valid !== 1'b0)
         $display("FAIL proto_body: got err %b req %b pop %b, required 10 0 0",
                  bus.err, bus.pl_req[1], bus.flit_out[1].control.valid);
      else passed++;
      do_reset();
      step(); idle_inputs();
      drive_flit(0, 1, 1, 16'h4001, 1);
      mid();
      step(); idle_inputs();
      bus.grant_valid[0] = 1'b1;
      bus.grant_pl[0]    = 4'b0011;
      mid();
      step(); idle_inputs();
      mid();
      checks++;
      if (bus.err !== 2'b10 || bus.alloc_valid[0] !== 1'b0 || bus.pl_req[0] !== 1'b1)
         $display("FAIL proto_grant: got err %b av %b req %b, required 10 0 1", bus.err, bus.alloc_valid[0], bus.pl_req[0]);
      else passed++;
      step(); idle_inputs();
      bus.grant_valid[0] = 1'b1;
      bus.grant_pl[0]    = 4'b1000;
      mid();
      step(); idle_inputs();
      mid();
      checks++;
      if (bus.alloc_valid[0] !== 1'b1 || bus.alloc_pl[0] !== 4'b1000)
         $display("FAIL proto_regrant: got av %b apl %b, required 1 1000", bus.alloc_valid[0], bus.alloc_pl[0]);
      else passed++;
      step(); idle_inputs();
      mid();
   endtask

   task automatic test_entry_and_reset();
      do_reset();
      step(); idle_inputs();
      drive_flit(3, 1, 0, 16'h5008, 0);
      drive_flit(0, 1, 0, 16'h5001, 0);
      mid();
      step(); idle_inputs();
      bus.grant_valid    = 4'b1001;
      bus.grant_pl[0]    = 4'b0001;
      bus.grant_pl[3]    = 4'b0001;
      bus.pl_blocked[0]  = 1'b1;
      mid();
      checks++;
      if (bus.pl_req !== 4'b0001) $display("FAIL entry_req: got %b, required 0001", bus.pl_req); else passed++;
      for (int k = 0; k < 3; k++) begin
         step(); idle_inputs();
         bus.pl_blocked[0] = 1'b1;
         mid();
         checks++;
         if (bus.pl_req[3] !== 1'b0 || bus.alloc_valid !== 4'b0001 || bus.out_port[3] !== 5'b01000)
            $display("FAIL entry_hold%0d: got req3 %b av %b port3 %b, required 0 0001 01000",
                     k, bus.pl_req[3], bus.alloc_valid, bus.out_port[3]);
         else passed++;
      end
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (bus.alloc_valid !== '0 || bus.alloc_pl !== '0 || bus.out_port !== '0 || bus.flit_out !== '0 ||
          bus.pl_req !== '0 || bus.full !== '0 || bus.err !== '0 || bus.credits_out !== '0)
         $display("FAIL async_reset: got av %b apl %h port %h req %b, required all 0",
                  bus.alloc_valid, bus.alloc_pl, bus.out_port, bus.pl_req);
      else passed++;
      idle_inputs();
      step();
      step();
      rst_n = 1'b1;
      mid();
      checks++;
      if (bus.flit_out !== '0 || bus.pl_req !== '0 || bus.out_port !== '0 || bus.alloc_valid !== '0)
         $display("FAIL post_reset: got flit %h req %b port %h, required all 0", bus.flit_out, bus.pl_req, bus.out_port);
      else passed++;
   endtask

   task automatic test_back_to_back();
      do_reset();
      step(); idle_inputs();
      drive_flit(0, 1, 1, 16'h6001, 1);
      mid();
      step(); idle_inputs();
      drive_flit(0, 1, 1, 16'h6002, 1);
      bus.grant_valid[0] = 1'b1;
      bus.grant_pl[0]    = 4'b0010;
      mid();
      step(); idle_inputs();
      mid();
      checks++;
      if (bus.pl_req[0] !== 1'b0 || bus.flit_out[0].control.valid !== 1'b1)
         $display("FAIL b2b_first: got req %b pop %b, required 0 1", bus.pl_req[0], bus.flit_out[0].control.valid);
      else passed++;
      step(); idle_inputs();
      bus.grant_valid[0] = 1'b1;
      bus.grant_pl[0]    = 4'b0100;
      mid();
      checks++;
      if (bus.pl_req[0] !== 1'b1 || bus.alloc_valid[0] !== 1'b0)
         $display("FAIL b2b_req: got req %b av %b, required 1 0", bus.pl_req[0], bus.alloc_valid[0]);
      else passed++;
      step(); idle_inputs();
      mid();
      checks++;
      if (bus.alloc_valid[0] !== 1'b1 || bus.alloc_pl[0] !== 4'b0100)
         $display("FAIL b2b_second: got av %b apl %b, required 1 0100", bus.alloc_valid[0], bus.alloc_pl[0]);
      else passed++;
      step(); idle_inputs();
      mid();
      step(); idle_inputs();
      mid();
   endtask

   initial begin
      test_reset();
      test_single_flit();
      test_blocked();
      test_overflow();
      test_protocol();
      test_back_to_back();
      test_entry_and_reset();
      step(); idle_inputs();
      mid();
      checks++;
      if (sb_q[0].size() + sb_q[1].size() + sb_q[2].size() + sb_q[3].size() != 0)
         $display("FAIL sb_leftover: got %0d unpopped flits, required 0",
                  sb_q[0].size() + sb_q[1].size() + sb_q[2].size() + sb_q[3].size());
      else passed++;
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
